// File: rtl/loader_pkg.sv
// Shared types and geometry for the tile buffer loader.
// The optional stride feature is selected with LOADER_STRIDE_EN.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    SHIFT
  } state_t;

  localparam int unsigned WORDS_PER_TILE = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned TILE_BYTES     = 64;
  localparam int unsigned WORDS_PER_ROW  = 2;
  localparam int unsigned K_W            = $clog2(WORDS_PER_TILE);

endpackage

// File: rtl/loader_addr_gen.sv
// Source-address generator: holds the latched base (and stride) and
// registers addr(k). The stride option (LOADER_STRIDE_EN) lives here.
module loader_addr_gen
  import loader_pkg::*;
#(
  parameter int ADDR_W = 16
`ifdef LOADER_STRIDE_EN
  ,
  parameter int STRIDE_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef LOADER_STRIDE_EN
  input  logic [STRIDE_W-1:0] row_stride,
`endif
  input  logic [K_W-1:0]    k_next,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] offset;

`ifdef LOADER_STRIDE_EN
  logic [STRIDE_W-1:0] stride_q;

  // Each tile row spans two words; row index times stride, plus word-in-row.
  always_comb begin
    offset = ADDR_W'(k_next[K_W-1:1]) * ADDR_W'(stride_q) + ADDR_W'(k_next[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= row_stride;
    end
  end
`else
  always_comb begin
    offset = ADDR_W'(k_next);
  end
`endif

  // Sum truncates to ADDR_W, so wrap past the top of memory is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      addr   <= '0;
    end else if (load) begin
      base_q <= base_addr;
      addr   <= base_addr;
    end else if (step) begin
      addr   <= base_q + offset;
    end
  end

endmodule

// File: rtl/tile_buffer_loader.sv
// Write-side controller: fetches a 16-word tile into the tile buffer and
// issues row-shift commands. LOADER_STRIDE_EN enables strided row fetch.
module tile_buffer_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int STRIDE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
`ifdef LOADER_STRIDE_EN
  input  logic [STRIDE_W-1:0] row_stride,
`endif
  input  logic                shift_req,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic                wr_en,
  output logic [5:0]          wr_addr,
  output logic [31:0]         wr_data,
  output logic                shift_en,
  output logic                busy,
  output logic                done,
  output logic                tile_valid
);

  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS_PER_TILE - 1);

  state_t         state;
  logic [K_W-1:0] k;
  logic           load;
  logic           step;

  assign load = (state == IDLE) && start;
  assign step = (state == FETCH) && (k != K_LAST);

  loader_addr_gen #(
    .ADDR_W   (ADDR_W)
`ifdef LOADER_STRIDE_EN
    ,
    .STRIDE_W (STRIDE_W)
`endif
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .base_addr  (base_addr),
`ifdef LOADER_STRIDE_EN
    .row_stride (row_stride),
`endif
    .k_next     (k + 1'b1),
    .addr       (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      mem_rd     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tile_valid <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      shift_en <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            k          <= '0;
            mem_rd     <= 1'b1;
            busy       <= 1'b1;
            tile_valid <= 1'b0;
          end else if (shift_req && tile_valid) begin
            state    <= SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          // Read data for word k arrives at this edge; write it next cycle.
          wr_en   <= 1'b1;
          wr_addr <= {k, 2'b00};
          wr_data <= mem_rdata;
          if (k == K_LAST) begin
            state      <= DRAIN;
            mem_rd     <= 1'b0;
            done       <= 1'b1;
            tile_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        SHIFT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_buffer_loader.sv
// Directed bench for tile_buffer_loader; covers LOADER_STRIDE_EN when defined.
module tb_tile_buffer_loader;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  stride;
    logic [15:0] first;
    logic [15:0] mid;
    logic [15:0] last;
  } load_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
`ifdef LOADER_STRIDE_EN
  logic [7:0]  row_stride;
`endif
  logic        shift_req;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        shift_en;
  logic        busy;
  logic        done;
  logic        tile_valid;

  int checks = 0;
  int errors = 0;
  load_vec_t vecs[3];

  always #5 clk = ~clk;

  // Source memory: word at address a is {4{a[7:0]}}, captured by the DUT next edge.
  assign mem_rdata = {4{mem_addr[7:0]}};

  tile_buffer_loader #(
    .ADDR_W   (16),
    .STRIDE_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
`ifdef LOADER_STRIDE_EN
    .row_stride (row_stride),
`endif
    .shift_req  (shift_req),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done),
    .tile_valid (tile_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_addr(input load_vec_t v, input int unsigned k);
`ifdef LOADER_STRIDE_EN
    return v.base + 16'((k >> 1) * v.stride) + 16'(k & 1);
`else
    return v.base + 16'(k);
`endif
  endfunction

  task automatic set_stride(input logic [7:0] s);
`ifdef LOADER_STRIDE_EN
    row_stride = s;
`else
    if (s == 8'hxx) $display("unreachable");
`endif
  endtask

  // Full 18-cycle load; cycle 0 is the start cycle.
  task automatic run_load(input load_vec_t v, input bit with_shift, input bit poke);
    logic [15:0] a;
    start     = 1'b1;
    base_addr = v.base;
    set_stride(v.stride);
    shift_req = with_shift;
    step();
    start     = 1'b0;
    shift_req = 1'b0;
    base_addr = 16'h5555;
    set_stride(8'd3);
    for (int c = 1; c <= 18; c++) begin
      chk("mem_rd", {31'b0, mem_rd}, {31'b0, (c <= 16)});
      if (c <= 16) begin
        a = exp_addr(v, c - 1);
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, a});
        if (c == 1)  chk("addr_first", {16'b0, mem_addr}, {16'b0, v.first});
        if (c == 9)  chk("addr_mid",   {16'b0, mem_addr}, {16'b0, v.mid});
        if (c == 16) chk("addr_last",  {16'b0, mem_addr}, {16'b0, v.last});
      end
      chk("wr_en", {31'b0, wr_en}, {31'b0, (c >= 2 && c <= 17)});
      if (c >= 2 && c <= 17) begin
        a = exp_addr(v, c - 2);
        chk("wr_addr", {26'b0, wr_addr}, 32'((c - 2) * 4));
        chk("wr_data", wr_data, {4{a[7:0]}});
      end
      chk("done",       {31'b0, done},       {31'b0, (c == 17)});
      chk("busy",       {31'b0, busy},       {31'b0, (c <= 17)});
      chk("tile_valid", {31'b0, tile_valid}, {31'b0, (c >= 17)});
      chk("shift_en",   {31'b0, shift_en},   32'd0);
      if (poke) begin
        start     = (c == 4 || c == 17);
        shift_req = (c == 9);
      end
      step();
    end
    start     = 1'b0;
    shift_req = 1'b0;
  endtask

  // One shift_req cycle must give exactly one shift_en pulse, one cycle later.
  task automatic run_shift();
    int pulses;
    pulses    = 0;
    shift_req = 1'b1;
    step();
    shift_req = 1'b0;
    chk("shift_en_pulse", {31'b0, shift_en}, 32'd1);
    chk("shift_busy",     {31'b0, busy},     32'd1);
    chk("shift_valid",    {31'b0, tile_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (shift_en) pulses++;
      step();
    end
    chk("shift_pulses", 32'(pulses), 32'd1);
    chk("shift_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
`ifdef LOADER_STRIDE_EN
    vecs[0] = '{16'h0000, 8'd10, 16'h0000, 16'h0028, 16'h0047};
    vecs[1] = '{16'hFFF8, 8'd2,  16'hFFF8, 16'h0000, 16'h0007};
    vecs[2] = '{16'h0100, 8'd3,  16'h0100, 16'h010C, 16'h0116};
`else
    vecs[0] = '{16'h0100, 8'd2, 16'h0100, 16'h0108, 16'h010F};
    vecs[1] = '{16'hFFF8, 8'd2, 16'hFFF8, 16'h0000, 16'h0007};
    vecs[2] = '{16'h1234, 8'd2, 16'h1234, 16'h123C, 16'h1243};
`endif
    rst       = 1'b1;
    start     = 1'b0;
    shift_req = 1'b0;
    base_addr = '0;
    set_stride(8'd0);
    step();
    step();
    chk("rst_outputs",
        {26'b0, mem_rd, wr_en, shift_en, busy, done, tile_valid}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_wr", {wr_data[31:6], wr_addr}, 32'd0);
    rst = 1'b0;
    step();

    // shift_req without a tile is ignored
    shift_req = 1'b1;
    step();
    shift_req = 1'b0;
    chk("shift_no_tile", {30'b0, shift_en, busy}, 32'd0);
    step();
    chk("shift_no_tile2", {30'b0, shift_en, busy}, 32'd0);

    // start/shift pokes while busy are ignored
    run_load(vecs[0], 1'b0, 1'b1);
    run_shift();

    // start beats a simultaneous shift_req; tile_valid drops
    run_load(vecs[1], 1'b1, 1'b0);
    run_shift();

    // reset in cycle 7 of a load
    start     = 1'b1;
    base_addr = vecs[2].base;
    set_stride(vecs[2].stride);
    step();
    start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    chk("mid_wr_en",   {31'b0, wr_en}, 32'd1);
    chk("mid_wr_addr", {26'b0, wr_addr}, 32'd20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outputs",
        {26'b0, mem_rd, wr_en, shift_en, busy, done, tile_valid}, 32'd0);
    step();
    chk("abort_idle", {30'b0, wr_en, busy}, 32'd0);

    run_load(vecs[2], 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
